// File: rtl/var_delay_pkg.sv
// Shared constants and helpers for the programmable sample delay line.
// Keeps the delay-select width and the load-time clamp rule in one place.
package var_delay_pkg;

   localparam int DEFAULT_WIDTH       = 34;
   localparam int DEFAULT_MAX_DEPTH   = 16;
   localparam int DEFAULT_RESET_DELAY = 5;

   function automatic int depthWidth(input int maxDepth);
      return $clog2(maxDepth + 1);
   endfunction

   // A zero request would leave no stage to read, so it becomes one cycle.
   function automatic int clampDelay(input int sel, input int maxDepth);
      if (sel < 1) begin
         return 1;
      end
      if (sel > maxDepth) begin
         return maxDepth;
      end
      return sel;
   endfunction

endpackage

// File: rtl/var_delay_path_stage.sv
// One tagged storage stage of the delay line: WIDTH data bits plus a valid bit,
// with shift enable and a synchronous valid-clear that leaves data untouched.
module delay_stage #(
   parameter int WIDTH = 34
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           en_i,
   input  logic           clr_i,
   input  logic [WIDTH:0] d_i,
   output logic [WIDTH:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (en_i) begin
            data_q <= d_i[WIDTH:1];
         end
         if (clr_i) begin
            valid_q <= 1'b0;
         end else if (en_i) begin
            valid_q <= d_i[0];
         end
      end
   end

   assign q_o = {data_q, valid_q};

endmodule

// File: rtl/var_delay_path.sv
// Runtime-programmable delay line aligning sample values with control paths.
// The output is read straight from stage D-1, so latency is D enabled cycles.
import var_delay_pkg::*;

module var_delay_path #(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int MAX_DEPTH   = DEFAULT_MAX_DEPTH,
   parameter int RESET_DELAY = DEFAULT_RESET_DELAY,
   localparam int DEPTH_W    = depthWidth(MAX_DEPTH)
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               Enable,
   input  logic [WIDTH-1:0]   VDin,
   input  logic               VDin_valid,
   input  logic [DEPTH_W-1:0] Delay_sel,
   input  logic               Delay_load,
   input  logic               Flush,
   output logic [WIDTH-1:0]   VDout,
   output logic               VDout_valid,
   output logic               Busy,
   output logic [DEPTH_W-1:0] Delay_cur
);

   localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   logic [DEPTH_W-1:0] delay_q, delay_d;
   logic [DEPTH_W-1:0] settle_q, settle_d;
   logic [DEPTH_W-1:0] delayClamped;
   logic [IDX_W-1:0]   outIdx;

   logic [MAX_DEPTH-1:0][WIDTH:0] stageIn;
   logic [MAX_DEPTH-1:0][WIDTH:0] stageOut;
   logic [MAX_DEPTH-1:0]          stageClr;

   assign delayClamped = DEPTH_W'(clampDelay(int'(Delay_sel), MAX_DEPTH));

   // A load restarts the settle count even if a previous refill is still running.
   always_comb begin
      delay_d  = delay_q;
      settle_d = settle_q;
      if (Delay_load) begin
         delay_d  = delayClamped;
         settle_d = delayClamped - 1'b1;
      end else if (Enable && (settle_q != '0)) begin
         settle_d = settle_q - 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         delay_q  <= DEPTH_W'(RESET_DELAY);
         settle_q <= '0;
      end else begin
         delay_q  <= delay_d;
         settle_q <= settle_d;
      end
   end

   // Stage0 keeps a sample captured on a load edge unless the shift is stalled or a flush drops it.
   assign stageClr[0] = Flush | (Delay_load & ~Enable);

   for (genvar k = 0; k < MAX_DEPTH; k++) begin : gStage
      if (k == 0) begin : gHead
         assign stageIn[k] = {VDin, VDin_valid};
      end else begin : gBody
         assign stageIn[k]  = stageOut[k-1];
         assign stageClr[k] = Flush | Delay_load;
      end

      delay_stage #(
         .WIDTH (WIDTH)
      ) uStage (
         .clk_i  (Clock),
         .rst_ni (Reset_n),
         .en_i   (Enable),
         .clr_i  (stageClr[k]),
         .d_i    (stageIn[k]),
         .q_o    (stageOut[k])
      );
   end

   assign outIdx                = IDX_W'(delay_q - 1'b1);
   assign {VDout, VDout_valid}  = stageOut[outIdx];
   assign Busy                  = (settle_q != '0);
   assign Delay_cur             = delay_q;

endmodule

// File: tb/tb_var_delay_path.sv
// Randomised and directed bench for var_delay_path against a sample-history model.
// The model indexes a history of accepted samples rather than tracking stages.
module tb_var_delay_path;

   localparam int WIDTH     = 34;
   localparam int MAX_DEPTH = 16;
   localparam int RST_DLY   = 5;
   localparam int DEPTH_W   = 5;

   logic               Clock = 1'b0;
   logic               Reset_n;
   logic               Enable;
   logic [WIDTH-1:0]   VDin;
   logic               VDin_valid;
   logic [DEPTH_W-1:0] Delay_sel;
   logic               Delay_load;
   logic               Flush;
   logic [WIDTH-1:0]   VDout;
   logic               VDout_valid;
   logic               Busy;
   logic [DEPTH_W-1:0] Delay_cur;

   int assertionCount = 0;
   int failCount      = 0;

   // Model state: every enabled edge appends one sample to the history.
   logic [WIDTH-1:0] hData[$];
   bit               hValid[$];
   int               mDelay;
   int               invBefore;
   int               loadCnt;
   int               settleLen;

   var_delay_path #(
      .WIDTH       (WIDTH),
      .MAX_DEPTH   (MAX_DEPTH),
      .RESET_DELAY (RST_DLY)
   ) dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .Enable      (Enable),
      .VDin        (VDin),
      .VDin_valid  (VDin_valid),
      .Delay_sel   (Delay_sel),
      .Delay_load  (Delay_load),
      .Flush       (Flush),
      .VDout       (VDout),
      .VDout_valid (VDout_valid),
      .Busy        (Busy),
      .Delay_cur   (Delay_cur)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertionCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      hData.delete();
      hValid.delete();
      mDelay    = RST_DLY;
      invBefore = 0;
      loadCnt   = 0;
      settleLen = 0;
   endtask

   // Compare the DUT against what the history says stage D-1 should hold now.
   task automatic compareModel(input string phase);
      int  idx;
      bit  expValid;
      bit  expBusy;
      logic [WIDTH-1:0] expData;
      idx      = hData.size() - mDelay;
      expValid = 1'b0;
      expData  = '0;
      if (idx >= 0) begin
         expValid = hValid[idx] && (idx >= invBefore);
         expData  = hData[idx];
      end
      expBusy = (hData.size() - loadCnt) < settleLen;
      checkOutput({phase, " VDout_valid"}, 64'(VDout_valid), 64'(expValid));
      checkOutput({phase, " Busy"}, 64'(Busy), 64'(expBusy));
      checkOutput({phase, " Delay_cur"}, 64'(Delay_cur), 64'(mDelay));
      if (expValid) begin
         checkOutput({phase, " VDout"}, 64'(VDout), 64'(expData));
      end
   endtask

   task automatic applyStimulus(input string phase, input bit en, input logic [WIDTH-1:0] din,
                                input bit dv, input int sel, input bit load, input bit flush);
      int newDelay;
      Enable     = en;
      VDin       = din;
      VDin_valid = dv;
      Delay_sel  = DEPTH_W'(sel);
      Delay_load = load;
      Flush      = flush;
      @(posedge Clock);
      #1;
      newDelay = sel;
      if (newDelay < 1) newDelay = 1;
      if (newDelay > MAX_DEPTH) newDelay = MAX_DEPTH;
      if (en) begin
         hData.push_back(din);
         hValid.push_back(dv);
      end
      if (flush) begin
         invBefore = hData.size();
      end else if (load) begin
         invBefore = en ? hData.size() - 1 : hData.size();
      end
      if (load) begin
         mDelay    = newDelay;
         loadCnt   = hData.size();
         settleLen = newDelay - 1;
      end
      compareModel(phase);
      Delay_load = 1'b0;
      Flush      = 1'b0;
   endtask

   task automatic checkResetState(input string phase);
      checkOutput({phase, " VDout"}, 64'(VDout), 64'd0);
      checkOutput({phase, " VDout_valid"}, 64'(VDout_valid), 64'd0);
      checkOutput({phase, " Busy"}, 64'(Busy), 64'd0);
      checkOutput({phase, " Delay_cur"}, 64'(Delay_cur), 64'(RST_DLY));
   endtask

   initial begin
      Reset_n    = 1'b0;
      Enable     = 1'b0;
      VDin       = '0;
      VDin_valid = 1'b0;
      Delay_sel  = '0;
      Delay_load = 1'b0;
      Flush      = 1'b0;
      modelReset();
      #12;
      checkResetState("reset");
      @(negedge Clock);
      Reset_n = 1'b1;

      $display("[TB] single sample at reset delay");
      applyStimulus("first", 1, 34'h3_0000_0001, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("first", 1, '0, 0, 0, 0, 0);
      applyStimulus("first", 1, '0, 0, 0, 0, 0);
      checkOutput("first latency5 valid", 64'(VDout_valid), 64'd1);
      checkOutput("first latency5 data", 64'(VDout), 64'h3_0000_0001);
      for (int i = 0; i < 3; i++) applyStimulus("first", 1, '0, 0, 0, 0, 0);

      $display("[TB] load delay 12 into counting stream");
      for (int i = 0; i < 20; i++) applyStimulus("count", 1, WIDTH'(i), 1, 0, 0, 0);
      applyStimulus("load12", 1, WIDTH'(100), 1, 12, 1, 0);
      for (int i = 1; i <= 11; i++) applyStimulus("settle12", 1, WIDTH'(100 + i), 1, 0, 0, 0);
      checkOutput("load12 first valid", 64'(VDout_valid), 64'd1);
      checkOutput("load12 first data", 64'(VDout), 64'd100);
      for (int i = 12; i < 24; i++) applyStimulus("post12", 1, WIDTH'(100 + i), 1, 0, 0, 0);

      $display("[TB] clamped delays");
      applyStimulus("load0", 1, WIDTH'(200), 1, 0, 1, 0);
      checkOutput("load0 Delay_cur", 64'(Delay_cur), 64'd1);
      for (int i = 1; i < 8; i++) applyStimulus("d1", 1, WIDTH'(200 + i), 1, 0, 0, 0);
      applyStimulus("load31", 1, WIDTH'(300), 1, 31, 1, 0);
      checkOutput("load31 Delay_cur", 64'(Delay_cur), 64'd16);
      for (int i = 1; i < 22; i++) applyStimulus("d16", 1, WIDTH'(300 + i), 1, 0, 0, 0);

      $display("[TB] flush at delay 5");
      applyStimulus("load5", 1, WIDTH'(400), 1, 5, 1, 0);
      for (int i = 1; i < 10; i++) applyStimulus("d5", 1, WIDTH'(400 + i), 1, 0, 0, 0);
      applyStimulus("flush", 1, WIDTH'(450), 1, 0, 0, 1);
      for (int i = 1; i < 10; i++) applyStimulus("postflush", 1, WIDTH'(450 + i), 1, 0, 0, 0);

      $display("[TB] enable stall mid-stream and mid-settle");
      applyStimulus("load8", 1, WIDTH'(500), 1, 8, 1, 0);
      for (int i = 1; i < 3; i++) applyStimulus("s8", 1, WIDTH'(500 + i), 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("stall", 0, WIDTH'(590 + i), 1, 0, 0, 0);
      for (int i = 3; i < 16; i++) applyStimulus("s8", 1, WIDTH'(500 + i), 1, 0, 0, 0);

      $display("[TB] async reset mid-settle");
      applyStimulus("load10", 1, WIDTH'(600), 1, 10, 1, 0);
      for (int i = 1; i < 4; i++) applyStimulus("s10", 1, WIDTH'(600 + i), 1, 0, 0, 0);
      checkOutput("s10 busy before reset", 64'(Busy), 64'd1);
      @(negedge Clock);
      #2;
      Reset_n = 1'b0;
      #1;
      checkResetState("async reset");
      modelReset();
      @(negedge Clock);
      Reset_n = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus("postreset", 1, '0, 0, 0, 0, 0);

      $display("[TB] randomised traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus("random", ($urandom_range(99, 0) < 85),
                       {2'($urandom_range(3, 0)), 32'($urandom())},
                       1'($urandom_range(1, 0)), $urandom_range(31, 0),
                       ($urandom_range(99, 0) < 3), ($urandom_range(99, 0) < 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
      $finish;
   end

endmodule

// File: doc/var_delay_path.md
# var_delay_path

Parametrised, runtime-programmable delay line for the value path of the arbitrary function generator. It replaces fixed-depth chains of 34-bit buffer registers with a single block that has a per-stage valid tag, a clock enable, a delay selectable from 1 to MAX_DEPTH cycles without resynthesis, a flush, and a settle indicator after each delay change. It sits between the waveform value generator and the DAC output formatter and aligns sample values with control/marker paths of differing latency.

## Interface
- WIDTH, 34: sample width in bits.
- MAX_DEPTH, 16: number of physical stages; maximum delay in cycles; minimum 2.
- RESET_DELAY, 5: delay in effect after reset; range 1..MAX_DEPTH.
- DEPTH_W, clog2(MAX_DEPTH+1): width of the delay-select field; derived, not overridden.

- Clock  in  1  single clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  shift enable; when low, all stages, valid tags and the settle counter hold.
- VDin  in  WIDTH  input sample.
- VDin_valid  in  1  input sample qualifier.
- Delay_sel  in  DEPTH_W  requested delay in cycles.
- Delay_load  in  1  one-cycle strobe; latches Delay_sel as the new delay.
- Flush  in  1  one-cycle strobe; invalidates all stored samples.
- VDout  out  WIDTH  delayed sample, taken directly from stage D-1 (registered, no output mux register).
- VDout_valid  out  1  valid tag of stage D-1.
- Busy  out  1  high while the line refills after Delay_load.
- Delay_cur  out  DEPTH_W  delay currently in effect (D).

## Operation
- Storage: MAX_DEPTH stages, each holding WIDTH data bits and 1 valid bit. When Enable=1, stage0 <= {VDin, VDin_valid} and stage k <= stage k-1.
- Output: VDout and VDout_valid are stage[D-1], so latency equals exactly D enabled cycles.
- Delay clamping on load: Delay_sel=0 becomes 1; Delay_sel>MAX_DEPTH becomes MAX_DEPTH.
- Delay_load edge:
  - D takes the clamped value.
  - Valid bits of stages 1..MAX_DEPTH-1 clear.
  - Stage0 captures {VDin, VDin_valid} if Enable=1, otherwise stage0 is invalidated.
  - Data bits are not cleared.
  - Settle counter loads D_new-1.
- Settle counter: decrements on each Enable=1 edge while nonzero. Busy = (counter != 0). With D_new=1, Busy never rises.
- Flush edge: all valid bits clear, including stage0, whose input is dropped. D and the counter are unchanged.
- Delay_load and Flush in the same cycle: Delay_load semantics apply, and stage0 is also invalidated (Flush wins for stage0).
- Delay_load while Busy: the new load restarts the counter from D_new-1. The last load wins.
- Enable=0 together with a strobe: the strobe still takes effect (clears, D update, counter load), but no shift occurs.
- Reset mid-operation: all state is forced to reset values immediately. Any sample in flight is lost.

## Timing
- Reset values:
  - VDout = 0, VDout_valid = 0, Busy = 0, Delay_cur = RESET_DELAY.
  - All stage data and valid bits = 0; settle counter = 0.
- Latency: a sample presented at enabled edge n appears at VDout after edge n+D-1, i.e. it is visible in the cycle following edge n+D-1. This gives D cycles with Enable continuously high.
- Delay_cur and the VDout source selection change on the edge that samples Delay_load.
- Busy rises on the Delay_load edge (if D_new>1) and falls on the edge that brings the counter to 0. This is the same edge on which a sample captured at the load edge reaches VDout.
- Strobes are level-sampled; holding one high for N cycles acts N times.

## Structure
- Shared package var_delay_pkg: the clog2-based DEPTH_W function, the default constants (34, 16, 5), and a clamp function for the delay.
- One sub-module, delay_stage: a WIDTH+1-bit register with async active-low reset, enable, and synchronous valid-clear input. It is instantiated MAX_DEPTH times in a generate loop.
- The top level holds the D register, the settle counter, the strobe priority logic and the output select.

## Test plan
- Reset, then drive VDin=0x3_0000_0001 valid with Enable=1 -> VDout=0x3_0000_0001 with VDout_valid=1 exactly 5 cycles later; Delay_cur=5; Busy=0 throughout.
- Stream a counting pattern, then Delay_load with Delay_sel=12 -> VDout_valid=0 for 11 cycles, Busy high 11 cycles; the sample captured on the load edge appears on the 12th cycle, and the stream then continues gap-free.
- Delay_sel=0 and Delay_sel=31 (MAX_DEPTH=16) -> Delay_cur=1 and 16 respectively; latency 1 and 16; Busy never rises for the delay-1 case.
- Flush mid-stream at D=5 -> VDout_valid=0 for 5 cycles (the flushed-cycle input is dropped), then valid resumes; Delay_cur unchanged.
- Enable low for 3 cycles mid-stream and mid-settle -> VDout, VDout_valid and the Busy count all freeze; latency measured in enabled cycles is still D.
- Assert Reset_n low mid-settle -> all outputs go to reset values asynchronously; after release, Delay_cur=5 and the line is empty.
